// File: rtl/clken_gen.sv
// clken_gen: multi-channel fractional clock-enable generator with PLL lock qualification.
// Each channel is a phase accumulator; new increments are swapped in only on a carry so periods stay whole.
module clken_gen #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]       cfg_inc,
  output logic                   ready,
  output logic [NCH-1:0]         ce
);

  localparam int unsigned CH_W  = $clog2(NCH);
  localparam int unsigned CNT_W = $clog2(LOCK_WAIT + 1);

  logic             sync_q;
  logic             lk_s;
  logic [CNT_W-1:0] lock_cnt;

  logic [ACC_W-1:0] acc      [NCH];
  logic [ACC_W-1:0] inc_act  [NCH];
  logic [ACC_W-1:0] inc_pend [NCH];
  logic [NCH-1:0]   pend;

  logic [ACC_W:0]   sum_c    [NCH];
  logic [NCH-1:0]   run_c;
  logic [NCH-1:0]   carry_c;
  logic [NCH-1:0]   xfer_c;
  logic [NCH-1:0]   wr_c;
  logic             cfg_hit_c;

  // Lock synchroniser and qualification counter; counter saturates at LOCK_WAIT.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      lk_s     <= 1'b0;
      lock_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      sync_q <= pll_locked;
      lk_s   <= sync_q;
      if (!lk_s) begin
        lock_cnt <= '0;
      end else if (lock_cnt != CNT_W'(LOCK_WAIT)) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end
      ready <= lk_s && (lock_cnt == CNT_W'(LOCK_WAIT));
    end
  end

  // Per-channel next-phase, carry, increment transfer and write decode.
  always_comb begin
    cfg_hit_c = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));
    run_c     = '0;
    carry_c   = '0;
    xfer_c    = '0;
    wr_c      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sum_c[i]   = {1'b0, acc[i]} + {1'b0, inc_act[i]};
      run_c[i]   = ready && lk_s && (inc_act[i] != '0);
      carry_c[i] = run_c[i] && sum_c[i][ACC_W];
      xfer_c[i]  = pend[i] && (carry_c[i] || (inc_act[i] == '0) || !ready);
      wr_c[i]    = cfg_hit_c && (cfg_ch == CH_W'(i));
    end
  end

  // A write landing on a transfer edge is captured as the next pending value.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      ce   <= '0;
      pend <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc[i]      <= '0;
        inc_act[i]  <= '0;
        inc_pend[i] <= '0;
      end
    end else begin
      ce <= carry_c;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!lk_s) begin
          acc[i] <= '0;
        end else if (run_c[i]) begin
          acc[i] <= sum_c[i][ACC_W-1:0];
        end
        if (xfer_c[i]) begin
          inc_act[i] <= inc_pend[i];
          pend[i]    <= 1'b0;
        end
        if (wr_c[i]) begin
          inc_pend[i] <= cfg_inc;
          pend[i]     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen: directed lock/update/reset sequences, rate table and random traffic
// checked every cycle against an arithmetic reference model.
module tb_clken_gen;

  localparam int unsigned NCH   = 3;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned LW    = 16;
  localparam int unsigned CH_W  = 2;
  localparam longint      MODV  = 64'd1 << ACC_W;

  logic             refclk = 1'b0;
  logic             rst_n;
  logic             pll_locked;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic             ready;
  logic [NCH-1:0]   ce;

  clken_gen #(.NCH(NCH), .ACC_W(ACC_W), .LOCK_WAIT(LW)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .ready(ready), .ce(ce)
  );

  always #5 refclk = ~refclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: lock tracked as run length of consecutive high samples.
  int             rl1, rl2;
  bit             m_rdy;
  logic [NCH-1:0] m_ce;
  longint         m_acc [NCH];
  longint         m_act [NCH];
  longint         m_pnd [NCH];
  bit             m_pf  [NCH];

  typedef struct {
    int ch;
    int inc;
    int win;
    int exp;
    int tol;
  } row_t;
  row_t rows [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    rl1 = 0; rl2 = 0; m_rdy = 1'b0; m_ce = '0;
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0; m_act[i] = 0; m_pnd[i] = 0; m_pf[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit             lks;
    bit             carry;
    longint         t;
    logic [NCH-1:0] nce;
    nce = '0;
    lks = (rl2 > 0);
    for (int i = 0; i < NCH; i++) begin
      carry = 1'b0;
      if (!lks) begin
        m_acc[i] = 0;
      end else if (m_rdy && m_act[i] != 0) begin
        t        = m_acc[i] + m_act[i];
        carry    = (t >= MODV);
        m_acc[i] = t % MODV;
      end
      nce[i] = carry;
      if (m_pf[i] && (carry || m_act[i] == 0 || !m_rdy)) begin
        m_act[i] = m_pnd[i];
        m_pf[i]  = 1'b0;
      end
      if (cfg_we && int'(cfg_ch) == i) begin
        m_pnd[i] = longint'(cfg_inc);
        m_pf[i]  = 1'b1;
      end
    end
    m_ce  = nce;
    m_rdy = (rl2 >= int'(LW) + 1);
    rl2   = rl1;
    rl1   = pll_locked ? ((rl1 < 100000) ? rl1 + 1 : rl1) : 0;
  endtask

  task automatic tick();
    @(posedge refclk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    cyc++;
    chk("ready", 32'(ready), 32'(m_rdy));
    chk("ce", 32'(ce), 32'(m_ce));
  endtask

  task automatic wr(input int ch, input int inc);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_inc = ACC_W'(inc);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic wait_ce(input int ch, input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (ce[ch]) begin
        at = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_ce%0d: no pulse within %0d cycles", ch, limit);
  endtask

  task automatic count_ce(input int ch, input int win, output int cnt);
    cnt = 0;
    for (int n = 0; n < win; n++) begin
      tick();
      if (ce[ch]) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, p2, p3, p4, p5, cnt, t0, dropn;

    rows[0] = '{0, 32'h400000, 1000, 250, 0};
    rows[1] = '{1, 32'h555555,  999, 333, 1};
    rows[2] = '{2, 32'h800000,  100,  50, 0};
    rows[3] = '{2, 32'h100000,  160,  10, 0};
    rows[4] = '{1, 32'h000000,   50,   0, 0};

    rst_n = 1'b0; pll_locked = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0;
    model_reset();
    #3;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    @(posedge refclk); #1;
    rst_n = 1'b1;
    cyc = 0;

    // Lock qualification: ready after edge LW+3, one-cycle dip restarts it.
    pll_locked = 1'b1;
    repeat (18) tick();
    chk("lock_edge18", 32'(ready), 32'd0);
    tick();
    chk("lock_edge19", 32'(ready), 32'd1);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    chk("dip_low", 32'(ready), 32'd0);
    repeat (16) tick();
    chk("relock_edge38", 32'(ready), 32'd0);
    tick();
    chk("relock_edge39", 32'(ready), 32'd1);

    // First-pulse latency from a stopped channel.
    wr(1, 32'h800000);
    tick(); chk("lat_t1", 32'(ce[1]), 32'd0);
    tick(); chk("lat_t2", 32'(ce[1]), 32'd0);
    tick(); chk("lat_t3", 32'(ce[1]), 32'd1);
    wr(1, 0);
    repeat (4) tick();

    // Rate table.
    for (int r = 0; r < 5; r++) begin
      wr(rows[r].ch, rows[r].inc);
      repeat (40) tick();
      count_ce(rows[r].ch, rows[r].win, cnt);
      total++;
      if (cnt < rows[r].exp - rows[r].tol || cnt > rows[r].exp + rows[r].tol) begin
        bad++;
        $display("FAIL rate_row%0d: count %0d want %0d+-%0d", r, cnt, rows[r].exp, rows[r].tol);
      end
    end

    // Glitch-free increment update on ch0 (running at period 4).
    wait_ce(0, 10, p0);
    tick();
    wr(0, 32'h200000);
    wait_ce(0, 10, p1);
    chk("upd_finish_period", 32'(p1 - p0), 32'd4);
    wait_ce(0, 20, p2);
    chk("upd_new_period", 32'(p2 - p1), 32'd8);
    repeat (2) tick();
    wr(0, 32'h400000);
    repeat (4) tick();
    wr(0, 32'h100000);
    p3 = cyc;
    chk("xfer_edge_carry", 32'(ce[0]), 32'd1);
    wait_ce(0, 10, p4);
    chk("xfer_first_period", 32'(p4 - p3), 32'd4);
    wait_ce(0, 30, p5);
    chk("xfer_second_period", 32'(p5 - p4), 32'd16);

    // Stop ch2, then an out-of-range write must not start anything.
    wr(2, 0);
    repeat (20) tick();
    count_ce(2, 50, cnt);
    chk("stop_ch2", 32'(cnt), 32'd0);
    wr(3, 32'h800000);
    count_ce(1, 50, cnt);
    chk("oor_ch1", 32'(cnt), 32'd0);
    count_ce(2, 50, cnt);
    chk("oor_ch2", 32'(cnt), 32'd0);

    // Random writes and lock drops against the model.
    dropn = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1;
        cfg_ch = CH_W'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       cfg_inc = '0;
          1:       cfg_inc = ACC_W'(32'h800000 + $urandom_range(0, 32'hFFFF));
          default: cfg_inc = ACC_W'($urandom_range(1, 32'hFFFFFF));
        endcase
      end else begin
        cfg_we = 1'b0;
      end
      if (dropn > 0) begin
        pll_locked = 1'b0;
        dropn--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 299) == 0) dropn = $urandom_range(1, 5);
      end
      tick();
    end
    cfg_we = 1'b0;
    pll_locked = 1'b1;
    repeat (40) tick();

    // Asynchronous reset with all channels running.
    wr(0, 32'hFFFFFF);
    wr(1, 32'h555555);
    wr(2, 32'h800000);
    repeat (30) tick();
    chk("pre_areset_ready", 32'(ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_ready", 32'(ready), 32'd0);
    chk("areset_ce", 32'(ce), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    t0 = cyc;
    repeat (18) tick();
    chk("rq_edge18", 32'(ready), 32'd0);
    tick();
    chk("rq_edge19", 32'(ready), 32'd1);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (ce != '0) cnt++;
    end
    chk("post_reset_idle", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
